// File: rtl/t06_button_conditioner_pkg.sv
// Shared types and constants for the snake-game button conditioner.
package t06_input_pkg;

   typedef enum logic [1:0] {
      RIGHT = 2'd0,
      LEFT  = 2'd1,
      UP    = 2'd2,
      DOWN  = 2'd3
   } dir_t;

   localparam int NUM_BTN   = 5;
   localparam int BTN_RIGHT = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_UP    = 2;
   localparam int BTN_DOWN  = 3;
   localparam int BTN_START = 4;

   // 10 ms at 10 MHz
   localparam int DB_CYCLES_DEFAULT = 100000;

   // Reversing straight back onto the snake's own body is never allowed.
   function automatic dir_t opposite(input dir_t d);
      dir_t r;
      case (d)
         RIGHT:   r = LEFT;
         LEFT:    r = RIGHT;
         UP:      r = DOWN;
         default: r = UP;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/t06_button_conditioner_if.sv
// Raw button inputs and conditioned outputs of the input stage.
interface t06_button_conditioner_if;
   logic       en;
   logic [4:0] btn_raw;
   logic [4:0] btn_level;
   logic [4:0] btn_press;
   logic [1:0] dir;
   logic       dir_changed;
   logic       paused;
   logic       any_press;

   // Board / stimulus side: drives pins and enable, observes results.
   modport master (
      output en, btn_raw,
      input  btn_level, btn_press, dir, dir_changed, paused, any_press
   );

   // Conditioner side.
   modport slave (
      input  en, btn_raw,
      output btn_level, btn_press, dir, dir_changed, paused, any_press
   );
endinterface

// File: rtl/t06_button_conditioner_debounce.sv
// One button bit: two-flop synchronizer, stability counter, debounced
// level and a one-cycle rising-edge pulse.
module t06_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic nrst,
   input  logic i_en,
   input  logic i_raw,
   output logic o_level,
   output logic o_press
);

   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   logic w_differ;
   logic w_expire;

   assign w_differ = (r_sync2 != r_level);
   assign w_expire = w_differ && (r_cnt == CNT_LAST);

   // Synchronize, count consecutive disagreeing cycles, flip the level once
   // the disagreement has lasted DB_CYCLES edges; everything freezes when
   // disabled except the pulse, which must not linger.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else if (!i_en) begin
         r_press <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_press <= w_expire && r_sync2;
         if (!w_differ) begin
            r_cnt <= '0;
         end else if (w_expire) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press & i_en;

endmodule

// File: rtl/t06_button_conditioner.sv
// Input stage for the snake core: five debounced buttons, press pulses,
// direction register with reversal rejection, and the pause toggle.
module t06_button_conditioner
   import t06_input_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input logic                      clk,
   input logic                      nrst,
   t06_button_conditioner_if.slave  bus
);

   logic [NUM_BTN-1:0] w_level;
   logic [NUM_BTN-1:0] w_press;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         t06_debounce #(
            .DB_CYCLES (DB_CYCLES)
         ) u_db (
            .clk     (clk),
            .nrst    (nrst),
            .i_en    (bus.en),
            .i_raw   (bus.btn_raw[gi]),
            .o_level (w_level[gi]),
            .o_press (w_press[gi])
         );
      end
   endgenerate

   dir_t r_dir;
   logic r_paused;
   logic r_dir_changed;

   dir_t w_cand;
   logic w_dir_req;
   logic w_accept;

   // Pick the highest-priority pressed direction; a rejected pick does not
   // fall back to a lower-priority button pressed in the same cycle.
   always_comb begin
      w_cand    = RIGHT;
      w_dir_req = 1'b1;
      if (w_press[BTN_RIGHT])     w_cand = RIGHT;
      else if (w_press[BTN_LEFT]) w_cand = LEFT;
      else if (w_press[BTN_UP])   w_cand = UP;
      else if (w_press[BTN_DOWN]) w_cand = DOWN;
      else                        w_dir_req = 1'b0;
      w_accept = w_dir_req && !r_paused
                 && (w_cand != r_dir) && (w_cand != opposite(r_dir));
   end

   // Direction and pause state; the direction decision uses the paused
   // value from before any same-cycle start toggle.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_dir         <= RIGHT;
         r_paused      <= 1'b1;
         r_dir_changed <= 1'b0;
      end else if (!bus.en) begin
         r_dir_changed <= 1'b0;
      end else begin
         r_dir_changed <= w_accept;
         if (w_accept) r_dir <= w_cand;
         if (w_press[BTN_START]) r_paused <= ~r_paused;
      end
   end

   assign bus.btn_level   = w_level;
   assign bus.btn_press   = w_press;
   assign bus.any_press   = |w_press;
   assign bus.dir         = r_dir;
   assign bus.dir_changed = r_dir_changed & bus.en;
   assign bus.paused      = r_paused;

endmodule

// File: tb/tb_t06_button_conditioner.sv
// Directed bench for the button conditioner with DB_CYCLES = 4.
module tb_t06_button_conditioner;

   logic clk = 1'b0;
   logic nrst;

   always #5 clk = ~clk;

   t06_button_conditioner_if bus ();

   t06_button_conditioner #(
      .DB_CYCLES (4)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] raw;
      int         cycles;
      logic [4:0] lvl;
      logic [1:0] dir;
      logic       paused;
      int         npress;
      int         ndc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run n cycles, counting press-pulse cycles, dir_changed cycles and any
   // cycle where any_press disagrees with the OR of btn_press.
   task automatic run(input int n, output int np, output int ndc, output int nbad);
      np = 0; ndc = 0; nbad = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (bus.any_press) np++;
         if (bus.dir_changed) ndc++;
         if (bus.any_press !== (|bus.btn_press)) nbad++;
      end
   endtask

   function automatic vec_t mk(input logic [4:0] raw, input int cyc, input logic [4:0] lvl,
                               input logic [1:0] dir, input logic paused, input int np, input int ndc);
      vec_t v;
      v.raw = raw; v.cycles = cyc; v.lvl = lvl; v.dir = dir;
      v.paused = paused; v.npress = np; v.ndc = ndc;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int np, ndc, nbad;

      // Bounce: three 3-cycle glitches on up never reach the level.
      for (int r = 0; r < 3; r++) begin
         vecs.push_back(mk(5'b00100, 3, 5'b00000, 2'd0, 1'b0, 0, 0));
         vecs.push_back(mk(5'b00000, 3, 5'b00000, 2'd0, 1'b0, 0, 0));
      end
      vecs.push_back(mk(5'b00010, 8, 5'b00010, 2'd0, 1'b0, 1, 0)); // left vs RIGHT: rejected
      vecs.push_back(mk(5'b00000, 8, 5'b00000, 2'd0, 1'b0, 0, 0));
      vecs.push_back(mk(5'b00100, 8, 5'b00100, 2'd2, 1'b0, 1, 1)); // up accepted
      vecs.push_back(mk(5'b00000, 8, 5'b00000, 2'd2, 1'b0, 0, 0));
      vecs.push_back(mk(5'b01000, 8, 5'b01000, 2'd2, 1'b0, 1, 0)); // down vs UP: rejected
      vecs.push_back(mk(5'b00000, 8, 5'b00000, 2'd2, 1'b0, 0, 0));
      vecs.push_back(mk(5'b00001, 8, 5'b00001, 2'd0, 1'b0, 1, 1)); // back to RIGHT
      vecs.push_back(mk(5'b00000, 8, 5'b00000, 2'd0, 1'b0, 0, 0));
      vecs.push_back(mk(5'b01100, 8, 5'b01100, 2'd2, 1'b0, 1, 1)); // up+down: up wins
      vecs.push_back(mk(5'b00000, 8, 5'b00000, 2'd2, 1'b0, 0, 0));
      vecs.push_back(mk(5'b10000, 8, 5'b10000, 2'd2, 1'b1, 1, 0)); // pause
      vecs.push_back(mk(5'b00000, 8, 5'b00000, 2'd2, 1'b1, 0, 0));
      vecs.push_back(mk(5'b00010, 8, 5'b00010, 2'd2, 1'b1, 1, 0)); // left while paused: discarded
      vecs.push_back(mk(5'b00000, 8, 5'b00000, 2'd2, 1'b1, 0, 0));
      vecs.push_back(mk(5'b10000, 8, 5'b10000, 2'd2, 1'b0, 1, 0)); // unpause, no queued change
      vecs.push_back(mk(5'b00000, 8, 5'b00000, 2'd2, 1'b0, 0, 0));

      // Reset with all buttons high.
      bus.en = 1'b1;
      bus.btn_raw = 5'b11111;
      nrst = 1'b0;
      tick();
      tick();
      check("reset dir", bus.dir, 0);
      check("reset paused", bus.paused, 1);
      check("reset level", bus.btn_level, 0);
      check("reset press", bus.btn_press, 0);
      check("reset dir_changed", bus.dir_changed, 0);
      check("reset any_press", bus.any_press, 0);
      $display("txn reset: dir=%0d paused=%0d level=%b", bus.dir, bus.paused, bus.btn_level);

      bus.btn_raw = 5'b00000;
      nrst = 1'b1;
      run(3, np, ndc, nbad);

      // Start partway through debounce, then reset: progress must be lost.
      bus.btn_raw = 5'b10000;
      run(4, np, ndc, nbad);
      check("abort level before reset", bus.btn_level, 0);
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check($sformatf("start edge%0d level", k), bus.btn_level[4], (k >= 6) ? 1 : 0);
         check($sformatf("start edge%0d press", k), bus.btn_press[4], (k == 6) ? 1 : 0);
         check($sformatf("start edge%0d paused", k), bus.paused, (k >= 7) ? 0 : 1);
      end
      $display("txn start press: paused=%0d level=%b", bus.paused, bus.btn_level);
      run(20, np, ndc, nbad);
      check("start held pulses", np, 0);
      check("start held paused", bus.paused, 0);
      check("start held level", bus.btn_level, 5'b10000);
      bus.btn_raw = 5'b00000;
      run(8, np, ndc, nbad);
      check("start release pulses", np, 0);
      check("start release level", bus.btn_level, 0);
      $display("txn start release: level=%b pulses=%0d", bus.btn_level, np);

      // Table-driven sequences.
      foreach (vecs[i]) begin
         bus.btn_raw = vecs[i].raw;
         run(vecs[i].cycles, np, ndc, nbad);
         check($sformatf("vec%0d level", i), bus.btn_level, vecs[i].lvl);
         check($sformatf("vec%0d dir", i), bus.dir, vecs[i].dir);
         check($sformatf("vec%0d paused", i), bus.paused, vecs[i].paused);
         check($sformatf("vec%0d press_cycles", i), np, vecs[i].npress);
         check($sformatf("vec%0d dir_changed_cycles", i), ndc, vecs[i].ndc);
         check($sformatf("vec%0d any_press_or", i), nbad, 0);
         $display("txn vec%0d: raw=%b level=%b dir=%0d paused=%0d presses=%0d dchg=%0d",
                  i, vecs[i].raw, bus.btn_level, bus.dir, bus.paused, np, ndc);
      end

      // Enable low freezes everything; right held meanwhile.
      bus.en = 1'b0;
      bus.btn_raw = 5'b00001;
      run(10, np, ndc, nbad);
      check("en0 pulses", np, 0);
      check("en0 level", bus.btn_level, 0);
      check("en0 dir", bus.dir, 2);
      check("en0 paused", bus.paused, 0);
      $display("txn en0 hold: level=%b dir=%0d pulses=%0d", bus.btn_level, bus.dir, np);
      bus.en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("en1 edge%0d press", k), bus.btn_press[0], (k == 6) ? 1 : 0);
         check($sformatf("en1 edge%0d level", k), bus.btn_level[0], (k >= 6) ? 1 : 0);
         check($sformatf("en1 edge%0d dir_changed", k), bus.dir_changed, (k == 7) ? 1 : 0);
         check($sformatf("en1 edge%0d dir", k), bus.dir, (k >= 7) ? 0 : 2);
      end
      $display("txn en1 resume: dir=%0d level=%b", bus.dir, bus.btn_level);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
